// File: rtl/button_conditioner_if.sv
// Button bus shared by the conditioner and its consumer.
// Raw levels flow in; debounced level and event pulses flow out.
interface button_conditioner_if #(
    parameter int NUM_CH = 5
);
    logic [NUM_CH-1:0] noisy_in;
    logic [NUM_CH-1:0] clean_out;
    logic [NUM_CH-1:0] rise_out;
    logic [NUM_CH-1:0] fall_out;
    logic [NUM_CH-1:0] repeat_out;

    modport master (
        output noisy_in,
        input  clean_out,
        input  rise_out,
        input  fall_out,
        input  repeat_out
    );

    modport slave (
        input  noisy_in,
        output clean_out,
        output rise_out,
        output fall_out,
        output repeat_out
    );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner: sync, debounce, edge pulses
// and hold-to-repeat, one independent lane per button.
module button_conditioner #(
    parameter int                NUM_CH          = 5,
    parameter int                DEBOUNCE_CYCLES = 1000000,
    parameter int                REPEAT_DELAY    = 25000000,
    parameter int                REPEAT_PERIOD   = 6500000,
    parameter logic [NUM_CH-1:0] REPEAT_EN       = 5'b11110
) (
    input logic                 clock_in,
    input logic                 reset_in,
    button_conditioner_if.slave bus
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] DLY_END = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_END = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_e;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic          s1_q, s2_q;
        logic          samp_q, samp_d;
        logic          clean_q, clean_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          rise_d, fall_d, rep_d;
        logic          rise_q, fall_q, rep_q;
        state_e        state_q, state_d;
        logic [TW-1:0] tmr_q, tmr_d;

        // Any change at s2 restarts the stability count.
        always_comb begin
            samp_d  = samp_q;
            cnt_d   = cnt_q;
            clean_d = clean_q;
            if (s2_q != samp_q) begin
                samp_d = s2_q;
                cnt_d  = '0;
            end else if (cnt_q == CNT_MAX) begin
                clean_d = samp_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        assign rise_d = clean_d & ~clean_q;
        assign fall_d = ~clean_d & clean_q;

        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            if (!clean_d) begin
                state_d = IDLE;
                tmr_d   = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise_d && REPEAT_EN[i]) begin
                            state_d = DELAY;
                            tmr_d   = '0;
                        end
                    end
                    DELAY: begin
                        if (tmr_q == DLY_END) begin
                            state_d = REPEAT;
                            tmr_d   = '0;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (tmr_q == PER_END) tmr_d = '0;
                        else tmr_d = tmr_q + 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end
                endcase
            end
        end

        always_comb begin
            rep_d = 1'b0;
            if (clean_d) begin
                unique case (state_q)
                    IDLE:    rep_d = rise_d;
                    DELAY:   rep_d = (tmr_q == DLY_END);
                    REPEAT:  rep_d = (tmr_q == PER_END);
                    default: rep_d = 1'b0;
                endcase
            end
        end

        always_ff @(posedge clock_in) begin
            if (reset_in) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                samp_q  <= 1'b0;
                cnt_q   <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                rep_q   <= 1'b0;
                state_q <= IDLE;
                tmr_q   <= '0;
            end else begin
                s1_q    <= bus.noisy_in[i];
                s2_q    <= s1_q;
                samp_q  <= samp_d;
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                rep_q   <= rep_d;
                state_q <= state_d;
                tmr_q   <= tmr_d;
            end
        end

        assign bus.clean_out[i]  = clean_q;
        assign bus.rise_out[i]   = rise_q;
        assign bus.fall_out[i]   = fall_q;
        assign bus.repeat_out[i] = rep_q;
    end
endmodule
